// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: lane geometry, lane indices, linear-layer
// rotation amounts, the permutation FSM state enum, the round-constant
// helper and the 5-bit S-box lookup.
package ascon_pkg;

   localparam int unsigned LANE_W  = 64;
   localparam int unsigned NLANE   = 5;
   localparam int unsigned STATE_W = LANE_W * NLANE;

   // Lane indices; x0 occupies the most significant 64 bits of the state.
   localparam int unsigned X0 = 0;
   localparam int unsigned X1 = 1;
   localparam int unsigned X2 = 2;
   localparam int unsigned X3 = 3;
   localparam int unsigned X4 = 4;

   // Linear layer: xi ^= (xi >>> ROT_A[i]) ^ (xi >>> ROT_B[i])
   localparam int unsigned ROT_A [NLANE] = '{19, 61, 1, 10, 7};
   localparam int unsigned ROT_B [NLANE] = '{28, 39, 6, 17, 41};

   // Round counter value of the final round
   localparam logic [3:0] RC_LAST = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SUB,
      ST_LIN,
      ST_DONE
   } perm_state_e;

   // Round constant byte injected into x2[7:0]
   function automatic logic [7:0] round_const(input logic [3:0] rc);
      return {~rc, rc};
   endfunction

   // Right rotation of one lane
   function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] x,
                                              input int unsigned n);
      return (x >> n) | (x << (LANE_W - n));
   endfunction

   // Ascon 5-bit S-box; input/output bit 4 is lane x0, bit 0 is lane x4
   function automatic logic [4:0] sbox5(input logic [4:0] x);
      logic [4:0] y;
      case (x)
         5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
         5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
         5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
         5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
         5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
         5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
         5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
         5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  default: y = 5'h17;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/ascon_sbox_slice.sv
// SLICE_W parallel combinational Ascon S-boxes.
// Ports:
//   x_i  in  NLANE x SLICE_W  lane slices, x_i[X0] is lane x0
//   y_o  out NLANE x SLICE_W  substituted lane slices
module ascon_sbox_slice
   import ascon_pkg::*;
#(
   parameter int unsigned SLICE_W = 16
) (
   input  logic [NLANE-1:0][SLICE_W-1:0] x_i,
   output logic [NLANE-1:0][SLICE_W-1:0] y_o
);

   // One S-box per column j: x0 bit is the S-box MSB
   always_comb begin
      y_o = '0;
      for (int j = 0; j < SLICE_W; j++) begin
         {y_o[X0][j], y_o[X1][j], y_o[X2][j], y_o[X3][j], y_o[X4][j]} =
            sbox5({x_i[X0][j], x_i[X1][j], x_i[X2][j], x_i[X3][j], x_i[X4][j]});
      end
   end

endmodule

// File: rtl/ascon_perm_serial.sv
// Slice-serial Ascon permutation (p6/p8/p12) with start/busy/done handshake.
// One SLICE_W-column S-box slice per cycle, then one linear-layer cycle per round.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request, accepted only in IDLE
//   rounds_i [3:0]  6, 8 or 12 (anything else runs 12), sampled with start
//   state_i [319:0] input state, x0 = [319:256] ... x4 = [63:0]
//   busy            high while the permutation runs
//   done            one-cycle pulse, state_o holds the result
//   state_o [319:0] permuted state
// Build option: ASCON_PERM_ZEROIZE_EN exposes the state only in the done
// cycle and clears it on the following cycle.
module ascon_perm_serial
   import ascon_pkg::*;
#(
   parameter int unsigned SLICE_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         rounds_i,
   input  logic [STATE_W-1:0] state_i,
   output logic               busy,
   output logic               done,
   output logic [STATE_W-1:0] state_o
);

   localparam int unsigned NSLICE = LANE_W / SLICE_W;
   localparam int unsigned K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned COL_W  = $clog2(LANE_W);
   localparam logic [K_W-1:0]    K_LAST     = K_W'(NSLICE - 1);
   localparam logic [LANE_W-1:0] SLICE_MASK = LANE_W'({SLICE_W{1'b1}});

   perm_state_e        state_q, state_d;
   logic [STATE_W-1:0] s_q, s_d;
   logic [3:0]         rc_q, rc_d;
   logic [K_W-1:0]     k_q, k_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [LANE_W-1:0]             lane [NLANE];
   logic [NLANE-1:0][SLICE_W-1:0] sb_in, sb_out;
   logic [COL_W-1:0]              col_base;
   logic [STATE_W-1:0]            sub_s, lin_s;

   assign col_base = COL_W'(k_q * SLICE_W);

   // Extract the current column slice; round constant joins at slice 0
   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         lane[i]  = s_q[STATE_W-1-LANE_W*i -: LANE_W];
         sb_in[i] = SLICE_W'(lane[i] >> col_base);
      end
      if (k_q == '0) begin
         sb_in[X2] = sb_in[X2] ^ SLICE_W'(round_const(rc_q));
      end
   end

   ascon_sbox_slice #(.SLICE_W(SLICE_W)) u_sbox (
      .x_i (sb_in),
      .y_o (sb_out)
   );

   // Merge substituted slice back in place; full-state linear layer
   always_comb begin
      sub_s = s_q;
      lin_s = s_q;
      for (int i = 0; i < NLANE; i++) begin
         sub_s[STATE_W-1-LANE_W*i -: LANE_W] =
            (lane[i] & ~(SLICE_MASK << col_base)) | (LANE_W'(sb_out[i]) << col_base);
         lin_s[STATE_W-1-LANE_W*i -: LANE_W] =
            lane[i] ^ rotr(lane[i], ROT_A[i]) ^ rotr(lane[i], ROT_B[i]);
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      rc_d    = rc_q;
      k_d     = k_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               s_d = state_i;
               case (rounds_i)
                  4'd6:    rc_d = 4'd6;
                  4'd8:    rc_d = 4'd4;
                  default: rc_d = 4'd0;
               endcase
               k_d     = '0;
               state_d = ST_SUB;
               busy_d  = 1'b1;
            end
         end
         ST_SUB: begin
            s_d    = sub_s;
            busy_d = 1'b1;
            if (k_q == K_LAST) begin
               state_d = ST_LIN;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         ST_LIN: begin
            s_d = lin_s;
            if (rc_q == RC_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               rc_d    = rc_q + 4'd1;
               k_d     = '0;
               state_d = ST_SUB;
               busy_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef ASCON_PERM_ZEROIZE_EN
            s_d = '0;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         rc_q    <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         rc_q    <= rc_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

`ifdef ASCON_PERM_ZEROIZE_EN
   assign state_o = done_q ? s_q : '0;
`else
   assign state_o = s_q;
`endif

endmodule

// File: tb/tb_ascon_perm_serial.sv
// Scoreboard bench for ascon_perm_serial: four instances (SLICE_W 8/16/32/64)
// share data inputs with individual start lines; a word-level Ascon model
// predicts results and timing, and a negedge monitor checks every cycle.
module tb_ascon_perm_serial;

   localparam int NW = 4;
   localparam int SW [NW] = '{8, 16, 32, 64};

   typedef struct {
      int           g;
      int           acc;
      int           done_cyc;
      logic [319:0] res;
   } job_t;

   typedef struct {
      int           g;
      int           cyc;
      logic [319:0] val;
   } probe_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_w [NW];
   logic [3:0]   rounds_i;
   logic [319:0] state_i;
   logic         busy_w  [NW];
   logic         done_w  [NW];
   logic [319:0] so_w    [NW];

   int           cyc = 0;
   logic         rst_seen = 1'b1;
   job_t         sb_q [$];
   probe_t       probe_q [$];
   logic [319:0] last_res [NW];
   int           n_checks = 0;
   int           n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NW; g++) begin : g_dut
      ascon_perm_serial #(.SLICE_W(SW[g])) u_dut (
         .clk      (clk),
         .rst      (rst),
         .start    (start_w[g]),
         .rounds_i (rounds_i),
         .state_i  (state_i),
         .busy     (busy_w[g]),
         .done     (done_w[g]),
         .state_o  (so_w[g])
      );
   end

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   // ---------------- reference model (64-bit word level) ----------------
   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic int eff_rounds(input logic [3:0] r);
      if (r == 4'd6) return 6;
      if (r == 4'd8) return 8;
      return 12;
   endfunction

   function automatic logic [319:0] add_const(input logic [319:0] s, input int r);
      logic [319:0] o;
      o = s;
      o[135:128] = o[135:128] ^ 8'(((15 - r) << 4) | r);
      return o;
   endfunction

   function automatic logic [319:0] sub_layer(input logic [319:0] s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      {x0, x1, x2, x3, x4} = s;
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] lin_layer(input logic [319:0] s);
      logic [63:0] x0, x1, x2, x3, x4;
      {x0, x1, x2, x3, x4} = s;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
      logic [319:0] st;
      st = s;
      for (int r = 12 - nr; r < 12; r++) st = lin_layer(sub_layer(add_const(st, r)));
      return st;
   endfunction

   // State after only the first S-box slice of the first round
   function automatic logic [319:0] ref_first_slice(input logic [319:0] s, input int nr,
                                                    input int w);
      logic [319:0] a, f, m;
      logic [63:0]  lm;
      a  = add_const(s, 12 - nr);
      f  = sub_layer(a);
      lm = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      m  = {lm, lm, lm, lm, lm};
      return (f & m) | (a & ~m);
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v;
      for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic chk(input string name, input int g, input logic [319:0] act,
                      input logic [319:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s inst%0d cyc %0d: got %h want %h", name, g, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      job_t e;
      logic eb, ed;
      if (rst_seen) begin
         sb_q.delete();
         probe_q.delete();
         for (int g = 0; g < NW; g++) last_res[g] = '0;
      end
      if (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
         if (probe_q[0].cyc == cyc)
            chk("first_slice", probe_q[0].g, so_w[probe_q[0].g], probe_q[0].val);
         void'(probe_q.pop_front());
      end
      for (int g = 0; g < NW; g++) begin
         eb = 1'b0;
         ed = 1'b0;
         if (sb_q.size() > 0 && sb_q[0].g == g) begin
            e  = sb_q[0];
            eb = (cyc >= e.acc) && (cyc < e.done_cyc);
            ed = (cyc == e.done_cyc);
         end
         chk("busy", g, 320'(busy_w[g]), 320'(eb));
         chk("done", g, 320'(done_w[g]), 320'(ed));
         if (ed) begin
            chk("result", g, so_w[g], e.res);
            last_res[g] = e.res;
            void'(sb_q.pop_front());
         end else if (!eb) begin
`ifdef ASCON_PERM_ZEROIZE_EN
            chk("idle_zero", g, so_w[g], '0);
`else
            chk("idle_hold", g, so_w[g], last_res[g]);
`endif
         end else begin
`ifdef ASCON_PERM_ZEROIZE_EN
            chk("busy_zero", g, so_w[g], '0);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at a negedge; the acceptance edge is the next posedge
   task automatic issue(input int g, input logic [319:0] st, input logic [3:0] r,
                        output int acc);
      job_t j;
      int   nr;
      nr         = eff_rounds(r);
      acc        = cyc + 1;
      j.g        = g;
      j.acc      = acc;
      j.done_cyc = acc + nr * (64 / SW[g] + 1);
      j.res      = ref_perm(st, nr);
      state_i    = st;
      rounds_i   = r;
      start_w[g] = 1'b1;
      sb_q.push_back(j);
      @(negedge clk);
      start_w[g] = 1'b0;
   endtask

   // Returns at the negedge of the cycle after done
   task automatic wait_done(input int g);
      for (int i = 0; i < 300 && done_w[g] !== 1'b1; i++) @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int           acc;
      logic [3:0]   rsel [4];
      logic [319:0] st;
      probe_t       p;

      rst      = 1'b1;
      rounds_i = 4'd12;
      state_i  = '0;
      for (int g = 0; g < NW; g++) start_w[g] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // p12 of the all-zero state on the 16-bit slice instance
      issue(1, '0, 4'd12, acc);
      wait_done(1);

      // Random states, every round count (plus an out-of-range value), every width
      for (int g = 0; g < NW; g++) begin
         rsel[0] = 4'd6;
         rsel[1] = 4'd8;
         rsel[2] = 4'd12;
         rsel[3] = 4'($urandom_range(13, 15));
         for (int k = 0; k < 4; k++) begin
            issue(g, rand320(), rsel[k], acc);
            wait_done(g);
         end
      end

      // Result must hold through a long idle period
      repeat (120) @(negedge clk);

      // Slice-0 constant injection (p6 on zero state uses 0x96)
      for (int g = 0; g < NW; g++) begin
         p.g   = g;
         p.cyc = cyc + 2;
`ifdef ASCON_PERM_ZEROIZE_EN
         p.val = '0;
`else
         p.val = ref_first_slice('0, 6, SW[g]);
`endif
         probe_q.push_back(p);
         issue(g, '0, 4'd6, acc);
         wait_done(g);
      end

      // Starts while busy and in the done cycle are ignored; DONE+1 is accepted
      issue(1, rand320(), 4'd12, acc);
      while (cyc < acc + 9) @(negedge clk);
      state_i    = rand320();
      rounds_i   = 4'd6;
      start_w[1] = 1'b1;
      @(negedge clk);
      start_w[1] = 1'b0;
      for (int i = 0; i < 300 && done_w[1] !== 1'b1; i++) @(negedge clk);
      st         = rand320();
      state_i    = st;
      rounds_i   = 4'd8;
      start_w[1] = 1'b1;
      @(negedge clk);
      issue(1, st, 4'd8, acc);
      wait_done(1);

      // Reset in cycle 20 of a p12 run aborts it; a fresh run then completes
      issue(1, rand320(), 4'd12, acc);
      while (cyc < acc + 19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      issue(1, rand320(), 4'd12, acc);
      wait_done(1);
      issue(3, rand320(), 4'd8, acc);
      wait_done(3);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ascon_perm_serial.md
# ascon_perm_serial

Self-sequenced, slice-serial Ascon permutation with a parametrised slice width and a run-time round count (p6/p8/p12). It applies the round-constant, S-box and linear layers to a 320-bit state, one SLICE_W-bit column slice per cycle. An internal FSM replaces the externally driven select lines of the previous generation with a start/busy/done handshake. It sits between the AEAD mode controller and the state register file.

## Interface
- SLICE_W, 16: columns per S-box cycle; legal values 8, 16, 32, 64.
- NSLICE, 64/SLICE_W: derived; slices per round.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- rounds_i  in  4  round count, sampled with start; 6, 8 or 12
- state_i  in  320  input state, sampled with start; x0=[319:256] … x4=[63:0]
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  single-cycle pulse; state_o valid
- state_o  out  320  permuted state

## Operation
- FSM states: IDLE, SUB, LIN, DONE.
- IDLE: if start=1, then S<=state_i, rc<=12-rounds_i, slice counter k<=0, go to SUB. rounds_i values other than 6 or 8 are treated as 12.
- SUB, one cycle per slice k=0..NSLICE-1:
  - Take column bits [k*SLICE_W +: SLICE_W] of x0..x4.
  - At k=0 only, XOR constant {~rc[3:0], rc[3:0]} into x2[7:0].
  - Apply the Ascon 5-bit S-box to each column and write the result back in place.
  - After k=NSLICE-1, go to LIN.
- LIN, one cycle: xi ^= (xi>>>a) ^ (xi>>>b) with (a,b) = x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
  - If rc=11, go to DONE.
  - Otherwise rc++, k<=0, go to SUB.
- DONE, one cycle: done=1, busy=0, then IDLE.
- start while busy=1, or in DONE, is ignored. It is neither queued nor an error.
- S holds its value in IDLE. A new start overwrites it.
- Reset values: busy=0, done=0, FSM=IDLE, k=0, rc=0, S=0, state_o=0.
- Reset mid-operation aborts the run on that edge. No done pulse is produced.

## Timing
- Acceptance edge is cycle 0. Each round takes NSLICE+1 cycles.
- done is high in cycle R*(NSLICE+1)+1, where R is the round count.
- Worked cases:
  - SLICE_W=16: p12 gives done in cycle 61; p6 gives done in cycle 31.
  - SLICE_W=64: p12 gives done in cycle 25.
- busy is high in cycles 1..R*(NSLICE+1).
- The earliest next accepted start is the DONE cycle+1. Back-to-back throughput is therefore R*(NSLICE+1)+2 cycles per permutation.
- state_o is driven from S with no combinational path from the inputs.

## Configuration
- ASCON_PERM_ZEROIZE_EN defined:
  - state_o = S only in the DONE cycle; it is 320'b0 otherwise.
  - S is cleared to 0 on the cycle after DONE.
- ASCON_PERM_ZEROIZE_EN undefined:
  - state_o = S always.
  - state_o holds the last result through IDLE until the next start.
  - Intermediate state is visible while busy.

## Structure
- Shared package ascon_pkg holds:
  - lane indices and rotation constants;
  - the FSM state enum;
  - the round-constant function rc -> {~rc, rc};
  - the 5-bit S-box lookup function.
- Sub-module ascon_sbox_slice, parametrised by SLICE_W: SLICE_W parallel combinational 5-bit S-boxes on five SLICE_W-bit lane slices.
- The linear layer is inline combinational logic.

## Test plan
- SLICE_W=16, start with state_i=0, rounds_i=12 -> done in cycle 61, busy high in cycles 1..60, state_o equal to the golden p12(0) from the team's reference model.
- rounds_i=6, then 8, then 12 on random states, each with SLICE_W in {8,16,32,64} -> state_o matches the model; latency is 6·/8·/12·(NSLICE+1)+1 cycles.
- rounds_i=6, state_i=0, inspect after the first SUB slice 0 -> the constant applied is 0x96. For the p12 first round the constant is 0xf0.
- start pulsed in cycle 10 of a run and again in the DONE cycle -> both ignored; the result is unchanged; the next start is accepted at DONE+1.
- rst asserted in cycle 20 of a p12 run -> the next cycle has busy=0, done=0, state_o=0, and no done pulse ever follows. A fresh start then completes normally.
- ASCON_PERM_ZEROIZE_EN on -> state_o is 0 in every cycle except DONE. With it off, state_o holds the result for at least 100 idle cycles.
